// File: rtl/edge_stamper.sv
// edge_stamper: write side of the delay line.
// Stamps synchronized trigger edges with count + delay and pushes them to the FIFO.
module edge_stamper #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trigger_in,
   input  logic             enable,
   input  logic [WIDTH-1:0] delay,
   input  logic [WIDTH-1:0] count,
   input  logic             full,
   input  logic             clear,
   output logic             wr_en,
   output logic [WIDTH-1:0] data_out,
   output logic             overflow,
   output logic [7:0]       drop_count
);

   typedef enum logic [1:0] {
      SM_IDLE,
      SM_WRITE,
      SM_HOLD
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   logic                   r_sync_prev;
   logic                   r_seen_low;
   logic [WIDTH-1:0]       r_data;
   logic                   r_overflow;
   logic [7:0]             r_drop_count;
   logic                   w_sync_out;
   logic                   w_edge;
   logic                   w_event;
   logic [WIDTH-1:0]       w_stamp;
   logic                   w_capture;
   logic                   w_drop;
   logic                   w_stale;
   logic                   w_record;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   // r_seen_low blocks a false edge when trigger_in is high across reset release
   assign w_edge     = w_sync_out & ~r_sync_prev & r_seen_low;
   assign w_event    = w_edge & enable;
   assign w_stamp    = count + delay;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync      <= '0;
         r_vld       <= '0;
         r_sync_prev <= 1'b0;
         r_seen_low  <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], trigger_in};
         r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_sync_prev <= w_sync_out;
         if (r_vld[SYNC_STAGES-1] && !w_sync_out)
            r_seen_low <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_drop       = 1'b0;
      w_stale      = 1'b0;
      unique case (r_state)
         SM_IDLE: begin
            if (w_event) begin
               w_capture    = 1'b1;
               w_state_next = full ? SM_HOLD : SM_WRITE;
            end
         end
         SM_WRITE: begin
            w_drop       = w_event;
            w_state_next = SM_IDLE;
         end
         SM_HOLD: begin
            w_drop = w_event;
            // stale wins over the FIFO draining in the same cycle
            if (count == r_data) begin
               w_stale      = 1'b1;
               w_state_next = SM_IDLE;
            end else if (!full) begin
               w_state_next = SM_WRITE;
            end
         end
         default: w_state_next = SM_IDLE;
      endcase
   end

   assign w_record = w_drop | w_stale;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= SM_IDLE;
         r_data       <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture)
            r_data <= w_stamp;
         if (clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
         end else if (w_record) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF)
               r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

   assign wr_en      = (r_state == SM_WRITE);
   assign data_out   = r_data;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_edge_stamper.sv
// tb_edge_stamper: scoreboard bench for edge_stamper.
// Expected stamps are queued at stimulus time and popped on each wr_en.
module tb_edge_stamper;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       trigger_in = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] delay = '0;
   logic [7:0] count = '0;
   logic       full = 1'b0;
   logic       clear = 1'b0;
   logic       wr_en;
   logic [7:0] data_out;
   logic       overflow;
   logic [7:0] drop_count;

   int         n_vec = 0;
   int         n_err = 0;
   int         n_wr = 0;
   logic       run_cnt = 1'b0;
   logic       prev_wr = 1'b0;
   logic [7:0] exp_q[$];

   edge_stamper #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .trigger_in (trigger_in),
      .enable     (enable),
      .delay      (delay),
      .count      (count),
      .full       (full),
      .clear      (clear),
      .wr_en      (wr_en),
      .data_out   (data_out),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run_cnt)
         count <= count + 8'd1;
   end

   always @(negedge clk) begin
      if (!reset && wr_en) begin
         n_wr++;
         chk("b2b_wr", prev_wr, 0);
         chk("wr_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0)
            chk("data_out", data_out, exp_q.pop_front());
      end
      prev_wr = wr_en;
   end

   task automatic fire();
      trigger_in = 1'b1;
      repeat (2) @(negedge clk);
      trigger_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

   initial begin
      int wr0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drops", drop_count, 0);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      // single edge with latency check
      count = 8'd10;
      delay = 8'd20;
      exp_q.push_back(8'd30);
      trigger_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("lat_early", wr_en, 0);
      @(negedge clk);
      chk("lat_wr", wr_en, 1);
      trigger_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("single_ovf", overflow, 0);

      // wrap-around
      count = 8'd250;
      delay = 8'd10;
      exp_q.push_back(8'd4);
      fire();
      repeat (3) @(negedge clk);

      // back-pressure
      count = 8'd50;
      delay = 8'd20;
      full  = 1'b1;
      exp_q.push_back(8'd70);
      fire();
      for (int i = 0; i < 5; i++) begin
         chk("bp_no_wr", wr_en, 0);
         @(negedge clk);
      end
      full = 1'b0;
      @(negedge clk);
      chk("bp_wr", wr_en, 1);
      @(negedge clk);
      chk("bp_ovf", overflow, 0);
      repeat (2) @(negedge clk);

      // stale entry
      count = 8'd100;
      delay = 8'd8;
      full  = 1'b1;
      fire();
      run_cnt = 1'b1;
      repeat (14) @(negedge clk);
      run_cnt = 1'b0;
      chk("stale_ovf", overflow, 1);
      chk("stale_drops", drop_count, 1);
      full = 1'b0;
      repeat (4) @(negedge clk);
      chk("stale_drops2", drop_count, 1);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_ovf", overflow, 0);
      chk("clr_drops", drop_count, 0);

      // drop during hold, then saturate
      count = 8'd20;
      delay = 8'd50;
      full  = 1'b1;
      fire();
      fire();
      chk("drop_one", drop_count, 1);
      chk("drop_ovf", overflow, 1);
      for (int i = 0; i < 260; i++)
         fire();
      chk("drop_sat", drop_count, 255);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("sat_clr_ovf", overflow, 0);
      chk("sat_clr_drops", drop_count, 0);
      exp_q.push_back(8'd70);
      full = 1'b0;
      repeat (3) @(negedge clk);

      // enable low ignores edges
      enable = 1'b0;
      wr0 = n_wr;
      fire();
      repeat (4) @(negedge clk);
      chk("en_no_wr", n_wr, wr0);
      chk("en_no_drop", drop_count, 0);
      enable = 1'b1;

      // reset mid-hold with trigger held high
      count = 8'd5;
      delay = 8'd40;
      full  = 1'b1;
      trigger_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_data", data_out, 45);
      reset = 1'b1;
      #1;
      chk("arst_wr", wr_en, 0);
      chk("arst_data", data_out, 0);
      chk("arst_drops", drop_count, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      full  = 1'b0;
      wr0   = n_wr;
      repeat (10) @(negedge clk);
      chk("held_no_wr", n_wr, wr0);
      trigger_in = 1'b0;
      repeat (4) @(negedge clk);
      exp_q.push_back(8'd45);
      trigger_in = 1'b1;
      repeat (6) @(negedge clk);
      trigger_in = 1'b0;
      chk("rearm_wr", n_wr, wr0 + 1);
      repeat (3) @(negedge clk);

      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
